// File: rtl/spike_delay_neuron.sv
// spike_delay_neuron: leaky integrate-and-fire neuron with refractory period
// and a programmable axonal delay line on its output spike.
module spike_delay_neuron #(
    parameter int Nbits = 4,
    parameter int DBITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [Nbits-1:0] input_current,
    input  logic signed [Nbits+3:0] threshold,
    input  logic [2:0]              decay_shift,
    input  logic [3:0]              refractory_period,
    input  logic [DBITS-1:0]        spike_delay,
    output logic                    spike_out,
    output logic signed [Nbits+3:0] membrane_potential,
    output logic                    refractory
);
    localparam int W = Nbits + 4;
    localparam int MAXD = (1 << DBITS) - 1;
    localparam logic [0:0] S_INT = 1'b0;
    localparam logic [0:0] S_REF = 1'b1;

    logic signed [W-1:0] r_v;
    logic [0:0]          r_state;
    logic [3:0]          r_cnt;
    logic [MAXD-1:0]     r_pend;
    logic                r_spike;

    logic signed [W-1:0] w_shifted;
    logic signed [W-1:0] w_leak;
    logic signed [W+1:0] w_sum;
    logic signed [W-1:0] w_vn;
    logic                w_fire;
    logic [MAXD-1:0]     w_dnew;

    // Shift kept in its own signed net so the zero-select below cannot turn it logical
    assign w_shifted = r_v >>> decay_shift;
    assign w_leak    = (decay_shift == 3'd0) ? '0 : w_shifted;
    assign w_sum     = {{2{r_v[W-1]}}, r_v} - {{2{w_leak[W-1]}}, w_leak}
                     + {{(W+2-Nbits){input_current[Nbits-1]}}, input_current};
    assign w_vn      = (w_sum[W+1:W-1] == 3'b000 || w_sum[W+1:W-1] == 3'b111) ? w_sum[W-1:0]
                     : (w_sum[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});
    assign w_fire    = (r_state == S_INT) && (w_vn >= threshold);
    assign w_dnew    = (w_fire && spike_delay != '0) ? (MAXD'(1) << (spike_delay - DBITS'(1))) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v     <= '0;
            r_state <= S_INT;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_spike <= 1'b0;
        end else if (enable) begin
            r_pend  <= (r_pend >> 1) | w_dnew;
            r_spike <= r_pend[0] | (w_fire && spike_delay == '0);
            if (r_state == S_INT) begin
                if (w_fire) begin
                    r_v <= '0;
                    if (refractory_period != 4'd0) begin
                        r_state <= S_REF;
                        r_cnt   <= refractory_period;
                    end
                end else begin
                    r_v <= w_vn;
                end
            end else begin
                r_v   <= '0;
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1)
                    r_state <= S_INT;
            end
        end else begin
            r_spike <= 1'b0;
        end
    end

    assign spike_out          = r_spike;
    assign membrane_potential = r_v;
    assign refractory         = (r_state == S_REF);
endmodule

// File: tb/tb_spike_delay_neuron.sv
// tb_spike_delay_neuron: directed vector table plus hand-written multi-cycle
// sequences (saturation, enable freeze, reset during refractory).
module tb_spike_delay_neuron;
    localparam int NB = 4;
    localparam int DB = 2;
    localparam int W  = NB + 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic signed [NB-1:0] input_current;
    logic signed [W-1:0]  threshold;
    logic [2:0]           decay_shift;
    logic [3:0]           refractory_period;
    logic [DB-1:0]        spike_delay;
    logic                 spike_out;
    logic signed [W-1:0]  membrane_potential;
    logic                 refractory;

    int n_chk  = 0;
    int n_fail = 0;

    spike_delay_neuron #(.Nbits(NB), .DBITS(DB)) dut (
        .clk(clk), .reset(reset), .enable(enable), .input_current(input_current),
        .threshold(threshold), .decay_shift(decay_shift), .refractory_period(refractory_period),
        .spike_delay(spike_delay), .spike_out(spike_out),
        .membrane_potential(membrane_potential), .refractory(refractory)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        logic  rst;
        logic  en;
        int    cur;
        int    thr;
        int    dec;
        int    rp;
        int    d;
        logic  sp;
        int    v;
        logic  rf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string tag, input logic rst, input logic en, input int cur, input int thr,
                       input int dec, input int rp, input int d, input logic sp, input int v, input logic rf);
        vec_t x;
        x.tag = tag; x.rst = rst; x.en = en; x.cur = cur; x.thr = thr; x.dec = dec;
        x.rp = rp; x.d = d; x.sp = sp; x.v = v; x.rf = rf;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check3(input string tag, input logic sp, input int v, input logic rf);
        chk({tag, ".spike"}, spike_out, sp);
        chk({tag, ".v"}, membrane_potential, v);
        chk({tag, ".refr"}, refractory, rf);
    endtask

    task automatic step(input logic rst, input logic en, input int cur, input int thr,
                        input int dec, input int rp, input int d);
        reset             = rst;
        enable            = en;
        input_current     = NB'(cur);
        threshold         = W'(thr);
        decay_shift       = 3'(dec);
        refractory_period = 4'(rp);
        spike_delay       = DB'(d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // basic fire, R=0 D=0: v 3,6,9 then fire every 4th edge
        add("p31e1", 0, 1, 3, 10, 0, 0, 0, 0, 3, 0);
        add("p31e2", 0, 1, 3, 10, 0, 0, 0, 0, 6, 0);
        add("p31e3", 0, 1, 3, 10, 0, 0, 0, 0, 9, 0);
        add("p31e4", 0, 1, 3, 10, 0, 0, 0, 1, 0, 0);
        add("p31e5", 0, 1, 3, 10, 0, 0, 0, 0, 3, 0);
        add("p31e6", 0, 1, 3, 10, 0, 0, 0, 0, 6, 0);
        add("p31e7", 0, 1, 3, 10, 0, 0, 0, 0, 9, 0);
        add("p31e8", 0, 1, 3, 10, 0, 0, 0, 1, 0, 0);
        add("rstA",  1, 1, 3, 10, 0, 0, 0, 0, 0, 0);
        // R=2 D=2; current during refractory is ignored
        add("p32e1", 0, 1, 3, 10, 0, 2, 2, 0, 3, 0);
        add("p32e2", 0, 1, 3, 10, 0, 2, 2, 0, 6, 0);
        add("p32e3", 0, 1, 3, 10, 0, 2, 2, 0, 9, 0);
        add("p32e4", 0, 1, 3, 10, 0, 2, 2, 0, 0, 1);
        add("p32e5", 0, 1, 7, 10, 0, 2, 2, 0, 0, 1);
        add("p32e6", 0, 1, 7, 10, 0, 2, 2, 1, 0, 0);
        add("p32e7", 0, 1, 3, 10, 0, 2, 2, 0, 3, 0);
        add("p32e8", 0, 1, 3, 10, 0, 2, 2, 0, 6, 0);
        add("rstB",  1, 1, 3, 10, 0, 0, 0, 0, 0, 0);
        // leak: decay=1 settles at 14, below threshold 15
        add("p33e1", 0, 1, 7, 15, 1, 0, 0, 0, 7, 0);
        add("p33e2", 0, 1, 7, 15, 1, 0, 0, 0, 11, 0);
        add("p33e3", 0, 1, 7, 15, 1, 0, 0, 0, 13, 0);
        add("p33e4", 0, 1, 7, 15, 1, 0, 0, 0, 14, 0);
        add("p33e5", 0, 1, 7, 15, 1, 0, 0, 0, 14, 0);
        add("p33e6", 0, 1, 7, 15, 1, 0, 0, 0, 14, 0);
        add("rstC",  1, 1, 0, 15, 0, 0, 0, 0, 0, 0);
        // fire D=3 then D=2: both land on the same edge and merge into one pulse
        add("mrg1",  0, 1, 1, 1, 0, 0, 3, 0, 0, 0);
        add("mrg2",  0, 1, 1, 1, 0, 0, 2, 0, 0, 0);
        add("mrg3",  0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add("mrg4",  0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
        add("mrg5",  0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add("rstD",  1, 1, 0, 1, 0, 0, 0, 0, 0, 0);

        reset = 1'b1; enable = 1'b0; input_current = '0; threshold = '0;
        decay_shift = '0; refractory_period = '0; spike_delay = '0;
        #1;
        check3("reset_async", 0, 0, 0);
        @(posedge clk);
        #1;
        check3("reset", 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].cur, vecs[i].thr, vecs[i].dec, vecs[i].rp, vecs[i].d);
            check3(vecs[i].tag, vecs[i].sp, vecs[i].v, vecs[i].rf);
        end

        // negative saturation at -128, never wraps or fires
        for (int k = 1; k <= 20; k++) begin
            step(0, 1, -8, 127, 0, 0, 0);
            check3($sformatf("sat%0d", k), 0, (-8 * k < -128) ? -128 : -8 * k, 0);
        end
        step(1, 0, 0, 127, 0, 0, 0);

        // enable low 3 cycles mid-integration and mid-delay
        step(0, 1, 3, 10, 0, 0, 2); check3("frz_e1", 0, 3, 0);
        step(0, 1, 3, 10, 0, 0, 2); check3("frz_e2", 0, 6, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 3, 10, 0, 0, 2); check3("frz_int", 0, 6, 0);
        end
        step(0, 1, 3, 10, 0, 0, 2); check3("frz_e3", 0, 9, 0);
        step(0, 1, 3, 10, 0, 0, 2); check3("frz_e4", 0, 0, 0);
        step(0, 1, 3, 10, 0, 0, 0); check3("frz_e5", 0, 3, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 3, 10, 0, 0, 0); check3("frz_dly", 0, 3, 0);
        end
        step(0, 1, 3, 10, 0, 0, 0); check3("frz_e6", 1, 6, 0);
        step(0, 0, 3, 10, 0, 0, 0); check3("frz_off", 0, 6, 0);
        step(1, 0, 0, 10, 0, 0, 0);

        // reset during refractory with a D=3 spike pending
        step(0, 1, 3, 10, 0, 5, 3); check3("rr_e1", 0, 3, 0);
        step(0, 1, 3, 10, 0, 5, 3); check3("rr_e2", 0, 6, 0);
        step(0, 1, 3, 10, 0, 5, 3); check3("rr_e3", 0, 9, 0);
        step(0, 1, 3, 10, 0, 5, 3); check3("rr_e4", 0, 0, 1);
        step(0, 1, 3, 10, 0, 5, 3); check3("rr_e5", 0, 0, 1);
        #2 reset = 1'b1;
        #1 check3("rr_async", 0, 0, 0);
        step(1, 1, 0, 10, 0, 5, 3); check3("rr_hold", 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 10, 0, 5, 3); check3($sformatf("rr_post%0d", k), 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spike_delay_neuron.md
SPIKE_DELAY_NEURON -- requirements
Module: spike_delay_neuron

Interface
REQ-001 SHALL have parameter Nbits, default 4: input_current width, signed two's complement.
REQ-002 SHALL have parameter DBITS, default 2: delay-select width; MAXD = 2^DBITS - 1 is the largest delay, in enabled cycles.
REQ-003 SHALL use W = Nbits+4 as the membrane width, signed.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous reset, active high.
REQ-006 SHALL have port enable, input, 1 bit: advances neuron state one step per cycle in which it is high.
REQ-007 SHALL have port input_current, input, Nbits bits: signed current, same format as the current calculator's saturated output.
REQ-008 SHALL have port threshold, input, W bits: signed firing threshold.
REQ-009 SHALL have port decay_shift, input, 3 bits: leak shift amount; 0 means no leak.
REQ-010 SHALL have port refractory_period, input, 4 bits: refractory length in enabled cycles.
REQ-011 SHALL have port spike_delay, input, DBITS bits: axonal delay in enabled cycles.
REQ-012 SHALL have port spike_out, output, 1 bit: delayed spike, one-clock pulse.
REQ-013 SHALL have port membrane_potential, output, W bits: current membrane register.
REQ-014 SHALL have port refractory, output, 1 bit: high while in state REFRACT.

Function
REQ-015 SHALL hold all state (v, FSM, counter, delay line, spike_out) unchanged, except spike_out forced to 0, on any clock edge with enable low.
REQ-016 SHALL implement FSM states INTEGRATE and REFRACT; refractory = (state == REFRACT).
REQ-017 SHALL, in INTEGRATE on an enabled edge, compute v_next = sat_W(v - leak + sext(input_current)) in W+2 bits, where leak = 0 if decay_shift = 0, else v >>> decay_shift (arithmetic shift, floor).
REQ-018 SHALL saturate sat_W to [-2^(W-1), 2^(W-1)-1].
REQ-019 SHALL assert fire when v_next >= threshold (signed compare); on fire, v <= 0.
REQ-020 SHALL, on fire with refractory_period > 0, enter REFRACT and load cnt = refractory_period; with refractory_period = 0, remain in INTEGRATE.
REQ-021 SHALL, in REFRACT on an enabled edge, hold v = 0, ignore input_current, and decrement cnt; when cnt = 1 before the edge, return to INTEGRATE, giving exactly refractory_period refractory steps.
REQ-022 SHALL sample spike_delay only at the fire step; later changes SHALL NOT affect spikes already pending.
REQ-023 SHALL implement the delay line pend[MAXD-1:0] such that on each enabled edge pend <= (pend >> 1) | (fire && D > 0 ? 1 << (D-1) : 0).
REQ-024 SHALL, on each enabled edge, set spike_out <= pend[0] | (fire && D == 0).
REQ-025 SHALL merge coincident pending spikes (OR) into a single one-clock pulse.
REQ-026 SHALL give spike latency D+1 enabled edges from the fire-step input: D = 0 pulses on the same edge that clears v.
REQ-027 SHALL apply the refractory load and delay-line shift on the same edge in which fire occurs.

Reset
REQ-028 SHALL, with reset high, asynchronously force v = 0, state = INTEGRATE, cnt = 0, pend = 0, spike_out = 0, refractory = 0.
REQ-029 SHALL discard spikes pending at reset (including mid-refractory or mid-delay); none emitted after release.
REQ-030 SHALL begin operation on the first enabled rising edge after reset deasserts.

Verification
REQ-031 SHALL verify: threshold=10, decay=0, R=0, D=0, current=3 every cycle -> v 3,6,9, then fire on 4th edge (v_next=12), v=0, spike_out high one clock at edge 4; repeats every 4 edges.
REQ-032 SHALL verify: as REQ-031 with R=2, D=2 -> refractory high for edges 5-6, v=0 there; integration resumes edge 7; spike_out pulses at edge 6.
REQ-033 SHALL verify: decay=1, threshold=15, current=7 -> v 7,11,13,14,14,... steady; no spike ever.
REQ-034 SHALL verify: threshold=127, decay=0, current=-8 for 20 edges -> v reaches -128 at edge 16 and stays; no wrap, no spike.
REQ-035 SHALL verify: enable toggled low for 3 cycles mid-integration and mid-delay -> state frozen, spike_out 0, pulse shifted by exactly 3 clocks.
REQ-036 SHALL verify: reset asserted during REFRACT with pending spike (D=3) -> all outputs 0 immediately; no spike_out after release.
